// File: rtl/vnu_param.sv
// Parametrised min-sum LDPC variable node unit: a two-stage pipeline that sums the
// intrinsic LLR with DV check messages and returns saturated extrinsic messages.
module vnu_param #(
   parameter int DV    = 3,
   parameter int MSG_W = 5,
   parameter int LLR_W = 5,
   parameter int OUT_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic                  first_iter,
   input  logic [DV*MSG_W-1:0]   X,
   input  logic [LLR_W-1:0]      Z,
   output logic                  out_valid,
   output logic [DV*OUT_W-1:0]   Y,
   output logic                  hard_decision
);

   localparam int MAX_W = (MSG_W > LLR_W) ? MSG_W : LLR_W;
   localparam int SUM_W = MAX_W + $clog2(DV + 1) + 1;
   // Saturation compare is done one bit wider than either side so both fit signed.
   localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W + 1 : OUT_W + 1;
   localparam logic signed [CMP_W-1:0] SAT_MAX = CMP_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [CMP_W-1:0] SAT_MIN = -SAT_MAX;

   function automatic logic signed [SUM_W-1:0] msg_to_t(input logic [MSG_W-1:0] m);
      logic signed [SUM_W-1:0] mag;
      mag = $signed(SUM_W'(m[MSG_W-2:0]));
      return m[MSG_W-1] ? -mag : mag;
   endfunction

   function automatic logic signed [SUM_W-1:0] llr_to_t(input logic [LLR_W-1:0] m);
      logic signed [SUM_W-1:0] mag;
      mag = $signed(SUM_W'(m[LLR_W-2:0]));
      return m[LLR_W-1] ? -mag : mag;
   endfunction

   logic signed [SUM_W-1:0] t_d [DV];
   logic signed [SUM_W-1:0] t_q [DV];
   logic signed [SUM_W-1:0] total_d, total_q;
   logic signed [SUM_W-1:0] tz_d, tz_q;
   logic                    fi_d, fi_q;
   logic                    v1_d, v1_q;
   logic [DV*OUT_W-1:0]     y_d, y_q;
   logic                    hd_d, hd_q;
   logic                    out_valid_d, out_valid_q;
   logic signed [SUM_W-1:0] ext;
   logic signed [CMP_W-1:0] ext_sat;
   logic [OUT_W-2:0]        ext_mag;

   always_comb begin
      tz_d    = llr_to_t(Z);
      total_d = tz_d;
      for (int i = 0; i < DV; i++) begin
         t_d[i]  = msg_to_t(X[i*MSG_W +: MSG_W]);
         total_d = total_d + t_d[i];
      end
      fi_d = first_iter;
      v1_d = in_valid;
   end

   // Extrinsic = total minus own channel; the clipped value is never -2^(OUT_W-1),
   // so the magnitude always fits and a negative result never has zero magnitude.
   always_comb begin
      y_d         = '0;
      ext         = '0;
      ext_sat     = '0;
      ext_mag     = '0;
      hd_d        = total_q[SUM_W-1];
      out_valid_d = v1_q;
      for (int i = 0; i < DV; i++) begin
         ext     = fi_q ? tz_q : total_q - t_q[i];
         ext_sat = CMP_W'(ext);
         if (ext_sat > SAT_MAX) begin
            ext_sat = SAT_MAX;
         end else if (ext_sat < SAT_MIN) begin
            ext_sat = SAT_MIN;
         end
         ext_mag = (OUT_W-1)'(ext_sat[CMP_W-1] ? -ext_sat : ext_sat);
         y_d[i*OUT_W +: OUT_W] = {ext_sat[CMP_W-1], ext_mag};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DV; i++) begin
            t_q[i] <= '0;
         end
         total_q     <= '0;
         tz_q        <= '0;
         fi_q        <= 1'b0;
         v1_q        <= 1'b0;
         y_q         <= '0;
         hd_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (en) begin
         for (int i = 0; i < DV; i++) begin
            t_q[i] <= t_d[i];
         end
         total_q     <= total_d;
         tz_q        <= tz_d;
         fi_q        <= fi_d;
         v1_q        <= v1_d;
         y_q         <= y_d;
         hd_q        <= hd_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign Y             = y_q;
   assign hard_decision = hd_q;

endmodule

// File: tb/tb_vnu_param.sv
// Directed bench for vnu_param: default configuration plus a DV=6 instance
// driven with hand-computed vectors.
module tb_vnu_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en;
   logic        inValid, firstIter;
   logic [14:0] x;
   logic [4:0]  z;
   logic        outValid, hd;
   logic [17:0] y;

   logic        inValid6, firstIter6;
   logic [23:0] x6;
   logic [5:0]  z6;
   logic        outValid6, hd6;
   logic [41:0] y6;

   int checkCount = 0;
   int errorCount = 0;

   vnu_param dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(inValid), .first_iter(firstIter),
      .X(x), .Z(z), .out_valid(outValid), .Y(y), .hard_decision(hd)
   );

   vnu_param #(.DV(6), .MSG_W(4), .LLR_W(6), .OUT_W(7)) dut6 (
      .clk(clk), .rst(rst), .en(en), .in_valid(inValid6), .first_iter(firstIter6),
      .X(x6), .Z(z6), .out_valid(outValid6), .Y(y6), .hard_decision(hd6)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic fi, input logic [14:0] xv, input logic [4:0] zv);
      inValid   = v;
      firstIter = fi;
      x         = xv;
      z         = zv;
   endtask

   task automatic applySweepStimulus(input logic v, input logic fi, input logic [23:0] xv, input logic [5:0] zv);
      inValid6   = v;
      firstIter6 = fi;
      x6         = xv;
      z6         = zv;
   endtask

   task automatic checkTransaction(input string tag, input logic [17:0] expY, input logic expHd);
      checkOutput({tag, ".valid"}, 64'(outValid), 64'(1));
      checkOutput({tag, ".y"}, 64'(y), 64'(expY));
      checkOutput({tag, ".hd"}, 64'(hd), 64'(expHd));
   endtask

   // One isolated transaction: checks the 2-edge latency and that no repeat follows.
   task automatic runSingle(input string tag, input logic fi, input logic [14:0] xv,
                            input logic [4:0] zv, input logic [17:0] expY, input logic expHd);
      applyStimulus(1'b1, fi, xv, zv);
      step();
      checkOutput({tag, ".lat"}, 64'(outValid), 64'(0));
      applyStimulus(1'b0, 1'b0, 15'h0, 5'h0);
      step();
      checkTransaction(tag, expY, expHd);
      step();
      checkOutput({tag, ".idle"}, 64'(outValid), 64'(0));
   endtask

   task automatic runSweep(input string tag, input logic fi, input logic [23:0] xv,
                           input logic [5:0] zv, input logic [41:0] expY, input logic expHd);
      applySweepStimulus(1'b1, fi, xv, zv);
      step();
      applySweepStimulus(1'b0, 1'b0, 24'h0, 6'h0);
      step();
      checkOutput({tag, ".valid"}, 64'(outValid6), 64'(1));
      checkOutput({tag, ".y"}, 64'(y6), 64'(expY));
      checkOutput({tag, ".hd"}, 64'(hd6), 64'(expHd));
      step();
      checkOutput({tag, ".idle"}, 64'(outValid6), 64'(0));
   endtask

   localparam logic [14:0] X_BASIC = {5'b10100, 5'b00001, 5'b00010};
   localparam logic [17:0] Y_BASIC = {6'b000110, 6'b000001, 6'b000000};
   localparam logic [17:0] Y_A     = {3{6'b000001}};
   localparam logic [17:0] Y_B     = {3{6'b100010}};
   localparam logic [14:0] X_C     = {5'b00000, 5'b00000, 5'b00001};
   localparam logic [17:0] Y_C     = {6'b000110, 6'b000110, 6'b000101};

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      applyStimulus(1'b0, 1'b0, 15'h0, 5'h0);
      applySweepStimulus(1'b0, 1'b0, 24'h0, 6'h0);
      step();
      step();
      checkOutput("reset.valid", 64'(outValid), 64'(0));
      checkOutput("reset.y", 64'(y), 64'(0));
      checkOutput("reset.hd", 64'(hd), 64'(0));
      checkOutput("reset.valid6", 64'(outValid6), 64'(0));
      checkOutput("reset.y6", 64'(y6), 64'(0));
      rst = 1'b0;

      runSingle("basic", 1'b0, X_BASIC, 5'b00011, Y_BASIC, 1'b0);
      runSingle("satpos", 1'b0, {3{5'b01111}}, 5'b01111, {3{6'b011111}}, 1'b0);
      runSingle("satneg", 1'b0, {3{5'b11111}}, 5'b11111, {3{6'b111111}}, 1'b1);
      runSingle("fiPos", 1'b1, {5'b00000, 5'b00000, 5'b01111}, 5'b10111, {3{6'b100111}}, 1'b0);
      runSingle("fiNeg", 1'b1, 15'h0, 5'b10111, {3{6'b100111}}, 1'b1);
      runSingle("negZero", 1'b0, {5'b10000, 5'b00000, 5'b10000}, 5'b00000, 18'h0, 1'b0);

      // Streaming with a two-edge stall right after the first vector is captured.
      applyStimulus(1'b1, 1'b0, 15'h0, 5'b00001);
      step();
      applyStimulus(1'b1, 1'b0, 15'h0, 5'b10010);
      en = 1'b0;
      step();
      checkOutput("stall1.valid", 64'(outValid), 64'(0));
      step();
      checkOutput("stall2.valid", 64'(outValid), 64'(0));
      en = 1'b1;
      step();
      checkTransaction("streamA", Y_A, 1'b0);
      applyStimulus(1'b1, 1'b0, X_C, 5'b00101);
      step();
      checkTransaction("streamB", Y_B, 1'b1);
      en = 1'b0;
      applyStimulus(1'b1, 1'b0, {3{5'b01111}}, 5'b01111);
      step();
      checkTransaction("holdB", Y_B, 1'b1);
      applyStimulus(1'b0, 1'b0, 15'h0, 5'h0);
      en = 1'b1;
      step();
      checkTransaction("streamC", Y_C, 1'b0);
      step();
      checkOutput("noDup.valid", 64'(outValid), 64'(0));

      // Reset with two transactions in flight, asserted while stalled.
      applyStimulus(1'b1, 1'b0, X_BASIC, 5'b00011);
      step();
      applyStimulus(1'b1, 1'b0, 15'h0, 5'b10010);
      step();
      checkTransaction("preRst", Y_BASIC, 1'b0);
      rst = 1'b1;
      en  = 1'b0;
      applyStimulus(1'b0, 1'b0, 15'h0, 5'h0);
      step();
      checkOutput("rst.valid", 64'(outValid), 64'(0));
      checkOutput("rst.y", 64'(y), 64'(0));
      checkOutput("rst.hd", 64'(hd), 64'(0));
      rst = 1'b0;
      en  = 1'b1;
      step();
      checkOutput("postRst1.valid", 64'(outValid), 64'(0));
      step();
      checkOutput("postRst2.valid", 64'(outValid), 64'(0));
      runSingle("afterRst", 1'b0, X_C, 5'b00101, Y_C, 1'b0);

      // DV=6, MSG_W=4, LLR_W=6, OUT_W=7: saturation at +/-63.
      runSweep("sw.satPos", 1'b0, {6{4'b0111}}, 6'b011111, {6{7'b0111111}}, 1'b0);
      runSweep("sw.satNeg", 1'b0, {6{4'b1111}}, 6'b111111, {6{7'b1111111}}, 1'b1);
      runSweep("sw.mixed", 1'b0,
               {4'b1001, 4'b0111, 4'b1000, 4'b0000, 4'b1010, 4'b0011}, 6'b000101,
               {7'b0001101, 7'b0000101, 7'b0001100, 7'b0001100, 7'b0001110, 7'b0001001}, 1'b0);
      runSweep("sw.edge", 1'b0, {4'b0000, {5{4'b0111}}}, 6'b011111,
               {7'b0111111, {5{7'b0111011}}}, 1'b0);
      runSweep("sw.first", 1'b1, 24'h0, 6'b110100, {6{7'b1010100}}, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/vnu_param.md
Name: vnu_param

Overview:
Parametrised variable node unit for the min-sum LDPC decoder. It generalises the fixed degree-3 VNU to any variable-node degree DV, with configurable message, intrinsic and output widths. Extrinsic outputs use symmetric saturation. A first-iteration mode broadcasts the intrinsic LLR. Valid tracking and an enable-based stall let the VNU sit between the intrinsic RAM / CNU message network and the CNU array.

Parameters:
DV, 3, variable-node degree (number of CNU message channels), >=2
MSG_W, 5, width of each sign-magnitude input message from the CNUs (MSB = sign)
LLR_W, 5, width of the sign-magnitude intrinsic LLR Z (MSB = sign)
OUT_W, 6, width of each sign-magnitude output message to the CNUs (MSB = sign)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  pipeline advance; 0 = stall (all registers hold)
in_valid  in  1  X/Z/first_iter valid this cycle
first_iter  in  1  1 = output the intrinsic LLR on every channel (iteration 0)
X  in  DV*MSG_W  CNU messages; channel i = X[i*MSG_W +: MSG_W]
Z  in  LLR_W  intrinsic LLR from intrinsic RAM
out_valid  out  1  Y/hard_decision valid
Y  out  DV*OUT_W  extrinsic messages; channel i = Y[i*OUT_W +: OUT_W], pairs with X channel i
hard_decision  out  1  bit estimate: 1 if total LLR < 0, else 0

Behaviour:
- Reset (rst=1 at clk edge, overrides en): out_valid=0, Y=0, hard_decision=0, all internal pipeline registers and valid bits = 0. A transaction in flight is discarded, with no output for it.
- Arithmetic domain: internal two's complement, width SUM_W = max(MSG_W,LLR_W) + clog2(DV+1) + 1. No internal overflow is possible.
- S-to-T conversion: value = sign ? -mag : +mag. Negative zero (sign=1, mag=0) = 0.
- Stage 1 (registered when en=1):
  - t_i = T(X[i]) for each channel i
  - total = T(Z) + sum of t_i
  - registers hold t_i, total, T(Z), first_iter and v1 = in_valid
- Stage 2 (registered when en=1):
  - e_i = first_iter ? T(Z) : total - t_i
  - saturate e_i to [-(2^(OUT_W-1)-1), +(2^(OUT_W-1)-1)]; the range is symmetric and -2^(OUT_W-1) is never produced
  - T-to-S conversion: zero is always emitted as +0 (all bits 0)
  - hard_decision <= (total < 0); this holds in first_iter mode too, since total still includes Z
  - out_valid <= v1
- Latency: 2 enabled clock edges from in_valid sample to out_valid. With continuous en, throughput is 1 transaction per cycle.
- Stall: en=0 freezes every register, including out_valid. Outputs stay stable and no data is lost or duplicated. in_valid is ignored while en=0.
- Non-valid slots:
  - registers still capture data when en=1 and in_valid=0
  - out_valid=0 for those slots
  - Y and hard_decision contents are don't-care when out_valid=0
- Simultaneous rst and en: rst wins.

Test Plan:
- Basic (defaults), in_valid=1, Z=00011 (+3), X0=00010 (+2), X1=00001 (+1), X2=10100 (-4) -> 2 edges later: out_valid=1, Y0=000000, Y1=000001, Y2=000110, hard_decision=0.
- Saturation: Z=+15, all X=+15 -> every Y=011111, hd=0. Then Z=-15, all X=-15 -> every Y=111111, hd=1.
- first_iter=1, Z=10111 (-7), X arbitrary (X0=+15) -> every Y=100111, hd=1 if total<0 (with X all 0: hd=1).
- Negative zero: Z=00000, X0=10000, X1=00000, X2=10000 -> every Y=000000 (no 100000), hd=0.
- Stall and streaming:
  - drive 3 back-to-back valid vectors; drop en for 2 cycles after the first edge
  - required: Y/out_valid hold during the stall, then results emerge in order with no duplicates
  - total cycles = 3 + 2 + 2
- Reset mid-operation: assert rst for 1 cycle while 2 transactions are in flight -> out_valid=0, Y=0, hd=0 on the next edge, and no stale output afterwards. A new vector applied after reset appears 2 edges later.
- Parameter sweep: DV=6, MSG_W=4, LLR_W=6, OUT_W=7; random vectors checked against a reference model (total, extrinsic, saturation at ±63).
